// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-address generator.
package pc_gen_pkg;

   // Default address width and the address type sized by it
   localparam int unsigned PC_ADDR_W = 32;
   typedef logic [PC_ADDR_W-1:0] pc_addr_t;

   // PC value loaded while reset is asserted
   localparam pc_addr_t PC_RESET_VECTOR = 32'h0000_0000;

   // Fetch FSM encoding
   typedef enum logic [1:0] {
      ST_BOOT      = 2'd0,
      ST_RUN       = 2'd1,
      ST_HALT_PEND = 2'd2,
      ST_HALTED    = 2'd3
   } pc_state_e;

   // Instruction-length steps in bytes
   localparam int unsigned STEP_C = 2;
   localparam int unsigned STEP_I = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pushes past full overwrite the oldest entry,
// count saturates at RAS_DEPTH, top is the most recently pushed entry.
module pc_ras
   import pc_gen_pkg::*;
#(
   parameter int unsigned ADDR_W    = PC_ADDR_W,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              pop_i,       // already qualified with !empty_o
   input  logic              flush_i,     // wins over push and pop
   input  logic [ADDR_W-1:0] push_addr_i,
   output logic [ADDR_W-1:0] top_o,
   output logic              empty_o
);

   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  top_ptr;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign top_ptr = wr_ptr_q - PTR_W'(1);
   assign top_o   = mem_q[top_ptr];
   assign empty_o = (cnt_q == '0);

   // Pointer/count next state; push+pop replaces the top in place
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else if (push_i && pop_i) begin
         wr_ptr_d = wr_ptr_q;
      end else if (push_i) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
      end else if (pop_i) begin
         wr_ptr_d = top_ptr;
         cnt_d    = cnt_q - CNT_W'(1);
      end
   end

   // Control registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Entry storage, no reset needed: count gates every read that matters
   always_ff @(posedge clk) begin
      if (!flush_i && push_i) begin
         if (pop_i) mem_q[top_ptr]  <= push_addr_i;
         else       mem_q[wr_ptr_q] <= push_addr_i;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: FSM, next-PC priority mux (trap > redirect >
// RAS pop > sequential), alignment check and request hold while not accepted.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned       ADDR_W       = PC_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_RESET_VECTOR),
   parameter int unsigned       RAS_DEPTH    = 4,
   parameter bit                C_EXT        = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              fetch_valid,
   input  logic              fetch_ready,
   output logic [ADDR_W-1:0] fetch_addr,
   input  logic              is_compressed,
   input  logic              stall,
   input  logic              trap_valid,
   input  logic [ADDR_W-1:0] trap_vector,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic              ras_push,
   input  logic [ADDR_W-1:0] ras_push_addr,
   input  logic              ras_pop,
   input  logic              halt_req,
   input  logic              resume,
   output logic              halted,
   output logic              misalign,
   output logic              ras_empty
);

   // Trap vectors are forced onto the legal instruction alignment
   localparam logic [ADDR_W-1:0] ALIGN_MASK = C_EXT ? ~ADDR_W'(1) : ~ADDR_W'(3);

   function automatic logic is_misaligned(input logic [ADDR_W-1:0] a);
      return a[0] | (!C_EXT && a[1]);
   endfunction

   pc_state_e         state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              misalign_q, misalign_d;

   logic              active;
   logic              take_trap, take_redir, take_pop, advance;
   logic [ADDR_W-1:0] step;
   logic [ADDR_W-1:0] ras_top;

   assign fetch_addr = pc_q;
   assign misalign   = misalign_q;

   // Redirect/pop/trap are honoured in every state except the boot cycle
   assign active     = (state_q != ST_BOOT);
   assign take_trap  = active && trap_valid;
   assign take_redir = active && !trap_valid && redirect_valid;
   assign take_pop   = active && !trap_valid && !redirect_valid && ras_pop && !ras_empty;
   assign advance    = fetch_valid && fetch_ready && !stall;
   assign step       = (C_EXT && is_compressed) ? ADDR_W'(STEP_C) : ADDR_W'(STEP_I);

   pc_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .rst         (rst),
      .push_i      (ras_push && !take_trap),
      .pop_i       (take_pop),
      .flush_i     (take_trap),
      .push_addr_i (ras_push_addr),
      .top_o       (ras_top),
      .empty_o     (ras_empty)
   );

   // Next-PC priority mux; a misaligned redirect holds the PC and flags it
   always_comb begin
      pc_d       = pc_q;
      misalign_d = 1'b0;
      if (take_trap) begin
         pc_d = trap_vector & ALIGN_MASK;
      end else if (take_redir) begin
         if (is_misaligned(redirect_target)) misalign_d = 1'b1;
         else                                pc_d       = redirect_target;
      end else if (take_pop) begin
         pc_d = ras_top;
      end else if (advance) begin
         pc_d = pc_q + step;
      end
   end

   // FSM next state and state-decoded outputs
   always_comb begin
      state_d     = state_q;
      fetch_valid = 1'b0;
      halted      = 1'b0;
      unique case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            fetch_valid = 1'b1;
            // An unaccepted request must complete before halting
            if (halt_req) state_d = fetch_ready ? ST_HALTED : ST_HALT_PEND;
         end
         ST_HALT_PEND: begin
            fetch_valid = 1'b1;
            if (fetch_ready) state_d = ST_HALTED;
         end
         ST_HALTED: begin
            halted = 1'b1;
            if (resume || trap_valid) state_d = ST_RUN;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // State, PC and misalign pulse registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Table-driven bench for pc_gen: one instance with C_EXT=1, one with C_EXT=0.
module tb_pc_gen;

   typedef struct packed {
      logic        ready;
      logic        comp;
      logic        stall;
      logic        trap;
      logic [31:0] tvec;
      logic        redir;
      logic [31:0] rtgt;
      logic        push;
      logic [31:0] paddr;
      logic        pop;
      logic        halt;
      logic        resume;
   } in_t;

   typedef struct packed {
      logic        fv;
      logic [31:0] addr;
      logic        halted;
      logic        mis;
      logic        empty;
   } exp_t;

   typedef struct packed {
      logic sel;   // 0 = dut_a (C_EXT=1), 1 = dut_b (C_EXT=0)
      in_t  in;
      exp_t exp;
   } vec_t;

   typedef struct packed {
      logic sel;
      exp_t e;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   in_t  in_a, in_b;
   logic        fv_a, halted_a, mis_a, empty_a;
   logic [31:0] addr_a;
   logic        fv_b, halted_b, mis_b, empty_b;
   logic [31:0] addr_b;
   exp_t got_a, got_b;

   int   n_vec  = 0;
   int   n_miss = 0;
   sb_t  sb_q[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   assign got_a = {fv_a, addr_a, halted_a, mis_a, empty_a};
   assign got_b = {fv_b, addr_b, halted_b, mis_b, empty_b};

   pc_gen #(.ADDR_W(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(4), .C_EXT(1'b1)) dut_a (
      .clk(clk), .rst(rst), .fetch_valid(fv_a), .fetch_ready(in_a.ready), .fetch_addr(addr_a),
      .is_compressed(in_a.comp), .stall(in_a.stall), .trap_valid(in_a.trap),
      .trap_vector(in_a.tvec), .redirect_valid(in_a.redir), .redirect_target(in_a.rtgt),
      .ras_push(in_a.push), .ras_push_addr(in_a.paddr), .ras_pop(in_a.pop),
      .halt_req(in_a.halt), .resume(in_a.resume), .halted(halted_a), .misalign(mis_a),
      .ras_empty(empty_a));

   pc_gen #(.ADDR_W(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(4), .C_EXT(1'b0)) dut_b (
      .clk(clk), .rst(rst), .fetch_valid(fv_b), .fetch_ready(in_b.ready), .fetch_addr(addr_b),
      .is_compressed(in_b.comp), .stall(in_b.stall), .trap_valid(in_b.trap),
      .trap_vector(in_b.tvec), .redirect_valid(in_b.redir), .redirect_target(in_b.rtgt),
      .ras_push(in_b.push), .ras_push_addr(in_b.paddr), .ras_pop(in_b.pop),
      .halt_req(in_b.halt), .resume(in_b.resume), .halted(halted_b), .misalign(mis_b),
      .ras_empty(empty_b));

   function automatic in_t din(input logic ready, input logic comp, input logic stall,
                               input logic trap, input logic [31:0] tvec,
                               input logic redir, input logic [31:0] rtgt,
                               input logic push, input logic [31:0] paddr,
                               input logic pop, input logic halt, input logic resume);
      in_t r;
      r = '{ready, comp, stall, trap, tvec, redir, rtgt, push, paddr, pop, halt, resume};
      return r;
   endfunction

   function automatic exp_t dx(input logic fv, input logic [31:0] addr, input logic halted,
                               input logic mis, input logic empty);
      exp_t r;
      r = '{fv, addr, halted, mis, empty};
      return r;
   endfunction

   task automatic check(input logic sel, input exp_t e, input string tag);
      exp_t g;
      g = sel ? got_b : got_a;
      n_vec++;
      if (g !== e) begin
         n_miss++;
         $display("FAIL %s dut_%s: got fv=%0b addr=%h halted=%0b mis=%0b empty=%0b, want fv=%0b addr=%h halted=%0b mis=%0b empty=%0b",
                  tag, sel ? "b" : "a", g.fv, g.addr, g.halted, g.mis, g.empty,
                  e.fv, e.addr, e.halted, e.mis, e.empty);
      end
   endtask

   // Drive one vector, queue its expectation, compare once the edge has produced it
   task automatic apply(input vec_t v, input int idx);
      sb_t s;
      if (v.sel) in_b = v.in;
      else       in_a = v.in;
      sb_q.push_back('{v.sel, v.exp});
      @(posedge clk);
      #1;
      s = sb_q.pop_front();
      check(s.sel, s.e, $sformatf("vec%0d", idx));
   endtask

   initial begin
      in_t d1, d0;
      d1 = din(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      d0 = din(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      in_a = d1;
      in_b = d0;

      // dut_a: sequential stepping, compressed beat, hold while not ready
      tbl.push_back('{0, d1,                                        dx(1, 32'h000, 0, 0, 1)}); // boot -> run
      tbl.push_back('{0, d1,                                        dx(1, 32'h004, 0, 0, 1)});
      tbl.push_back('{0, d1,                                        dx(1, 32'h008, 0, 0, 1)});
      tbl.push_back('{0, din(1,1,0, 0,0, 0,0, 0,0, 0,0,0),          dx(1, 32'h00A, 0, 0, 1)});
      tbl.push_back('{0, d1,                                        dx(1, 32'h00E, 0, 0, 1)});
      tbl.push_back('{0, din(1,0,0, 0,0, 1,32'h10, 0,0, 0,0,0),     dx(1, 32'h010, 0, 0, 1)});
      tbl.push_back('{0, din(0,0,0, 0,0, 0,0, 0,0, 0,0,0),          dx(1, 32'h010, 0, 0, 1)});
      tbl.push_back('{0, din(0,0,1, 0,0, 0,0, 0,0, 0,0,0),          dx(1, 32'h010, 0, 0, 1)});
      tbl.push_back('{0, din(0,0,0, 0,0, 0,0, 0,0, 0,0,0),          dx(1, 32'h010, 0, 0, 1)});
      tbl.push_back('{0, d1,                                        dx(1, 32'h014, 0, 0, 1)});
      tbl.push_back('{0, din(1,0,1, 0,0, 0,0, 1,32'h50, 0,0,0),     dx(1, 32'h014, 0, 0, 0)}); // stall + push
      // trap beats redirect and pop, clears bit0, flushes RAS, drops push
      tbl.push_back('{0, din(1,0,0, 1,32'h103, 1,32'h200, 1,32'h60, 1,0,0), dx(1, 32'h102, 0, 0, 1)});
      tbl.push_back('{0, d1,                                        dx(1, 32'h106, 0, 0, 1)});
      tbl.push_back('{0, din(1,0,0, 0,0, 1,32'h201, 0,0, 0,0,0),    dx(1, 32'h106, 0, 1, 1)}); // misaligned
      tbl.push_back('{0, d1,                                        dx(1, 32'h10A, 0, 0, 1)});
      // RAS: five pushes into depth 4, then five pops
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 1,32'hA0, 0,0,0),     dx(1, 32'h10E, 0, 0, 0)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 1,32'hB0, 0,0,0),     dx(1, 32'h112, 0, 0, 0)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 1,32'hC0, 0,0,0),     dx(1, 32'h116, 0, 0, 0)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 1,32'hD0, 0,0,0),     dx(1, 32'h11A, 0, 0, 0)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 1,32'hE0, 0,0,0),     dx(1, 32'h11E, 0, 0, 0)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 0,0, 1,0,0),          dx(1, 32'h0E0, 0, 0, 0)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 0,0, 1,0,0),          dx(1, 32'h0D0, 0, 0, 0)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 0,0, 1,0,0),          dx(1, 32'h0C0, 0, 0, 0)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 0,0, 1,0,0),          dx(1, 32'h0B0, 0, 0, 1)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 0,0, 1,0,0),          dx(1, 32'h0B4, 0, 0, 1)}); // empty pop
      // push and pop together replace the top
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 1,32'h300, 0,0,0),    dx(1, 32'h0B8, 0, 0, 0)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 1,32'h310, 0,0,0),    dx(1, 32'h0BC, 0, 0, 0)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 1,32'h320, 1,0,0),    dx(1, 32'h310, 0, 0, 0)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 0,0, 1,0,0),          dx(1, 32'h320, 0, 0, 0)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 0,0, 1,0,0),          dx(1, 32'h300, 0, 0, 1)});
      // halt with an outstanding request, redirect while halted, resume
      tbl.push_back('{0, din(0,0,0, 0,0, 0,0, 0,0, 0,1,0),          dx(1, 32'h300, 0, 0, 1)});
      tbl.push_back('{0, d1,                                        dx(0, 32'h304, 1, 0, 1)});
      tbl.push_back('{0, d1,                                        dx(0, 32'h304, 1, 0, 1)});
      tbl.push_back('{0, din(1,0,0, 0,0, 1,32'h400, 0,0, 0,0,0),    dx(0, 32'h400, 1, 0, 1)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 0,0, 0,0,1),          dx(1, 32'h400, 0, 0, 1)});
      tbl.push_back('{0, d1,                                        dx(1, 32'h404, 0, 0, 1)});
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 0,0, 0,1,0),          dx(0, 32'h408, 1, 0, 1)});
      tbl.push_back('{0, din(1,0,0, 1,32'h500, 0,0, 0,0, 0,0,0),    dx(1, 32'h500, 0, 0, 1)}); // trap leaves HALTED
      tbl.push_back('{0, din(1,0,0, 1,32'h600, 0,0, 0,0, 0,1,0),    dx(0, 32'h600, 1, 0, 1)}); // trap + halt
      tbl.push_back('{0, din(1,0,0, 0,0, 0,0, 0,0, 0,0,1),          dx(1, 32'h600, 0, 0, 1)});
      // address wrap
      tbl.push_back('{0, din(1,0,0, 0,0, 1,32'hFFFF_FFFC, 0,0, 0,0,0), dx(1, 32'hFFFF_FFFC, 0, 0, 1)});
      tbl.push_back('{0, d1,                                        dx(1, 32'h000, 0, 0, 1)});
      tbl.push_back('{0, din(0,0,0, 0,0, 0,0, 1,32'h700, 0,0,0),    dx(1, 32'h000, 0, 0, 0)});

      // reset state while rst is held
      #22;
      check(0, dx(0, 32'h0, 0, 0, 1), "reset_a");
      check(1, dx(0, 32'h0, 0, 0, 1), "reset_b");
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // asynchronous reset mid-handshake with RAS non-empty
      in_a = d0;
      #3;
      rst = 1'b1;
      #1;
      check(0, dx(0, 32'h0, 0, 0, 1), "async_rst");
      @(posedge clk);
      #1;
      check(0, dx(0, 32'h0, 0, 0, 1), "rst_held");
      #3;
      rst = 1'b0;
      #1;
      check(0, dx(0, 32'h0, 0, 0, 1), "boot_cycle");
      @(posedge clk);
      #1;
      check(0, dx(1, 32'h0, 0, 0, 1), "boot_to_run");

      // dut_b (C_EXT=0): compressed ignored, bit1 cleared on trap, bit1 misalign
      tbl.delete();
      tbl.push_back('{1, din(1,1,0, 0,0, 0,0, 1,32'h40, 0,0,0),     dx(1, 32'h004, 0, 0, 0)});
      tbl.push_back('{1, din(1,0,0, 1,32'h103, 1,32'h200, 0,0, 1,0,0), dx(1, 32'h100, 0, 0, 1)});
      tbl.push_back('{1, din(1,0,0, 0,0, 1,32'h202, 0,0, 0,0,0),    dx(1, 32'h100, 0, 1, 1)});
      tbl.push_back('{1, din(1,0,0, 0,0, 0,0, 0,0, 0,0,0),          dx(1, 32'h104, 0, 0, 1)});
      tbl.push_back('{1, din(1,0,0, 0,0, 1,32'h201, 0,0, 0,0,0),    dx(1, 32'h104, 0, 1, 1)});
      tbl.push_back('{1, din(1,0,0, 0,0, 1,32'h208, 0,0, 0,0,0),    dx(1, 32'h208, 0, 0, 1)});
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 100 + i);

      if (sb_q.size() != 0) begin
         n_miss++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
